// File: rtl/spi_host_loader.sv
// SPI mode-0 host: frames a valid/ready word stream into CS-low transactions on CS/SCLK/MOSI.
// Define SPI_HOST_RX_EN to capture MISO into rx_data_o/rx_valid_o; otherwise both are tied to 0.
module spi_host_loader #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_last_i,
    output logic              rx_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              busy_o,
    output logic              spi_cs_o,
    output logic              spi_sclk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int HW = $clog2(2 * DATA_W);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     div_q, div_d;
    logic [HW-1:0]     half_q, half_d;
    logic [GW-1:0]     gap_q, gap_d;
    // MSB goes straight to MOSI on load, so only the remaining bits are kept.
    logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
    logic              last_q, last_d;
    logic              cs_q, cs_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              sample_rise;
    logic              word_done;
    logic              accept;

    assign tx_ready_o = !rst_i && ((state_q == S_IDLE) || (state_q == S_NEXT));
    assign accept     = tx_valid_i && tx_ready_o;
    assign busy_o     = (state_q != S_IDLE);
    assign spi_cs_o   = cs_q;
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        half_d      = half_q;
        gap_d       = gap_q;
        tx_shift_d  = tx_shift_q;
        last_d      = last_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        sample_rise = 1'b0;
        word_done   = 1'b0;
        case (state_q)
            S_IDLE, S_NEXT: begin
                if (accept) begin
                    tx_shift_d = tx_data_i[DATA_W-2:0];
                    mosi_d     = tx_data_i[DATA_W-1];
                    last_d     = tx_last_i;
                    cs_d       = 1'b0;
                    div_d      = '0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d       = '0;
                    half_d      = '0;
                    sclk_d      = 1'b1;
                    sample_rise = 1'b1;
                    state_d     = S_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (half_q == HALF_LAST) begin
                        word_done = 1'b1;
                        state_d   = last_q ? S_HOLD : S_NEXT;
                    end else begin
                        half_d = half_q + 1'b1;
                        sclk_d = !sclk_q;
                        if (sclk_q) begin
                            mosi_d     = tx_shift_q[DATA_W-2];
                            tx_shift_d = tx_shift_q << 1;
                        end else begin
                            sample_rise = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    gap_d   = '0;
                    cs_d    = 1'b1;
                    state_d = S_GAP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            half_q     <= '0;
            gap_q      <= '0;
            tx_shift_q <= '0;
            last_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            half_q     <= half_d;
            gap_q      <= gap_d;
            tx_shift_q <= tx_shift_d;
            last_q     <= last_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

`ifdef SPI_HOST_RX_EN
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;

    // MISO is sampled on the same clk edge that raises SCLK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= word_done;
            if (sample_rise) begin
                rx_shift_q <= {rx_shift_q[DATA_W-2:0], spi_miso_i};
            end
            if (word_done) begin
                rx_data_q <= rx_shift_q;
            end
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
`else
    logic unused_rx;
    assign unused_rx  = sample_rise ^ word_done ^ spi_miso_i;
    assign rx_valid_o = 1'b0;
    assign rx_data_o  = '0;
`endif

endmodule

// File: tb/tb_spi_host_loader.sv
// Directed bench for spi_host_loader: one CLK_DIV=2 instance and one CLK_DIV=1 instance.
module tb_spi_host_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       miso = 1'b0;
    logic       rdy0, rdy1, rxv0, rxv1, busy0, busy1;
    logic       cs0, cs1, sclk0, sclk1, mosi0, mosi1;
    logic [7:0] rxd0, rxd1;

    logic       sel = 1'b0;
    logic       mon_clr = 1'b0;
    logic       miso_rand = 1'b0;
    logic [7:0] tgt_word = 8'h00;

    int passed = 0;
    int total = 0;

    always #5 clk = !clk;

    spi_host_loader #(.DATA_W(8), .CLK_DIV(2), .CS_GAP(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .tx_valid_i(v0), .tx_ready_o(rdy0),
        .tx_data_i(tx_data), .tx_last_i(tx_last), .rx_valid_o(rxv0), .rx_data_o(rxd0),
        .busy_o(busy0), .spi_cs_o(cs0), .spi_sclk_o(sclk0), .spi_mosi_o(mosi0),
        .spi_miso_i(miso)
    );

    spi_host_loader #(.DATA_W(8), .CLK_DIV(1), .CS_GAP(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .tx_valid_i(v1), .tx_ready_o(rdy1),
        .tx_data_i(tx_data), .tx_last_i(tx_last), .rx_valid_o(rxv1), .rx_data_o(rxd1),
        .busy_o(busy1), .spi_cs_o(cs1), .spi_sclk_o(sclk1), .spi_mosi_o(mosi1),
        .spi_miso_i(miso)
    );

    logic       m_cs, m_sclk, m_mosi, m_rdy, m_rxv, m_busy;
    logic [7:0] m_rxd;
    assign m_cs   = sel ? cs1   : cs0;
    assign m_sclk = sel ? sclk1 : sclk0;
    assign m_mosi = sel ? mosi1 : mosi0;
    assign m_rdy  = sel ? rdy1  : rdy0;
    assign m_rxv  = sel ? rxv1  : rxv0;
    assign m_rxd  = sel ? rxd1  : rxd0;
    assign m_busy = sel ? busy1 : busy0;

    // Pin monitor plus a mode-0 target model that shifts tgt_word out on MISO.
    int rises, cs_falls, cs_low_run, cs_low_len, hi_run, min_gap, rx_pulses, edge_viol;
    int sh_run, sh_min, sh_max, ready_delay, gap_timer, nwords, rx_nz, tgt_bit;
    logic       gap_armed;
    logic [7:0] rx_last, mosi_acc;
    logic [7:0] words [16];
    logic       p_sclk = 1'b0, p_cs = 1'b1;

    always @(negedge clk) begin
        if (mon_clr) begin
            rises = 0; cs_falls = 0; cs_low_run = 0; cs_low_len = 0; hi_run = 0;
            min_gap = 1000; rx_pulses = 0; edge_viol = 0; sh_run = 0; sh_min = 1000;
            sh_max = 0; ready_delay = -1; gap_timer = 0; nwords = 0; rx_nz = 0;
            gap_armed = 1'b0; rx_last = 8'h00; mosi_acc = 8'h00;
        end else begin
            if (m_sclk && !p_sclk) begin
                rises++;
                mosi_acc = {mosi_acc[6:0], m_mosi};
                if ((rises % 8) == 0 && nwords < 16) begin
                    words[nwords] = mosi_acc;
                    nwords++;
                end
            end
            if (m_sclk) begin
                sh_run++;
            end else if (p_sclk) begin
                if (sh_run < sh_min) sh_min = sh_run;
                if (sh_run > sh_max) sh_max = sh_run;
                sh_run = 0;
                tgt_bit = (tgt_bit + 1) % 8;
            end
            if ((m_cs != p_cs) && m_sclk) edge_viol++;
            if (!m_cs && p_cs) begin
                if (cs_falls > 0 && hi_run < min_gap) min_gap = hi_run;
                cs_falls++;
                cs_low_run = 0;
            end
            if (m_cs && !p_cs) begin
                cs_low_len = cs_low_run;
                gap_armed = 1'b1;
                gap_timer = 0;
            end else if (gap_armed) begin
                gap_timer++;
                if (m_rdy) begin
                    ready_delay = gap_timer;
                    gap_armed = 1'b0;
                end
            end
            if (!m_cs) begin
                cs_low_run++;
                hi_run = 0;
            end else begin
                hi_run++;
            end
            if (m_rxv) begin
                rx_pulses++;
                rx_last = m_rxd;
            end
            if (m_rxv || m_rxd != 8'h00) rx_nz++;
        end
        if (m_cs) tgt_bit = 0;
        miso = miso_rand ? 1'($urandom_range(1)) : tgt_word[7 - tgt_bit];
        p_sclk = m_sclk;
        p_cs = m_cs;
    end

    task clr();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(negedge clk);
    endtask

    task push(input logic [7:0] d, input logic l, input logic s);
        int n;
        n = 0;
        tx_data = d;
        tx_last = l;
        if (s) v1 = 1'b1; else v0 = 1'b1;
        while (!(s ? rdy1 : rdy0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            $display("FAIL push_timeout: word %h not accepted, got ready=0 want 1", d);
        end
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task wait_ready(input string tag);
        int n;
        n = 0;
        while (!m_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            $display("FAIL %s_ready_timeout: got ready=0 want 1", tag);
        end
    endtask

    task wait_idle(input string tag);
        int n;
        n = 0;
        while ((m_busy || !m_rdy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            $display("FAIL %s_idle_timeout: got busy=%0b want 0", tag, m_busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (cs0 !== 1'b1) $display("FAIL rst_cs: got %b want 1", cs0); else passed++;
        total++; if (sclk0 !== 1'b0) $display("FAIL rst_sclk: got %b want 0", sclk0); else passed++;
        total++; if (mosi0 !== 1'b0) $display("FAIL rst_mosi: got %b want 0", mosi0); else passed++;
        total++; if (rxv0 !== 1'b0 || rxd0 !== 8'h00) $display("FAIL rst_rx: got %b/%h want 0/00", rxv0, rxd0); else passed++;
        total++; if (busy0 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy0); else passed++;
        total++; if (rdy0 !== 1'b0) $display("FAIL rst_ready_in_reset: got %b want 0", rdy0); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (rdy0 !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", rdy0); else passed++;
        $display("test_reset done");
    endtask

    task test_single();
        sel = 1'b0;
        tgt_word = 8'h00;
        clr();
        push(8'hA5, 1'b1, 1'b0);
        wait_idle("single");
        total++; if (cs_low_len !== 36) $display("FAIL single_cs_low: got %0d want 36", cs_low_len); else passed++;
        total++; if (rises !== 8) $display("FAIL single_rises: got %0d want 8", rises); else passed++;
        total++; if (nwords !== 1 || words[0] !== 8'hA5) $display("FAIL single_mosi: got %0d words, %h want 1, a5", nwords, words[0]); else passed++;
        total++; if (edge_viol !== 0) $display("FAIL single_sclk_at_cs_edge: got %0d want 0", edge_viol); else passed++;
        total++; if (ready_delay !== 2) $display("FAIL single_ready_gap: got %0d want 2", ready_delay); else passed++;
        total++; if (cs_falls !== 1) $display("FAIL single_cs_falls: got %0d want 1", cs_falls); else passed++;
        $display("test_single: frame a5 cs_low=%0d rises=%0d", cs_low_len, rises);
    endtask

    task test_rx();
        sel = 1'b0;
        tgt_word = 8'h3C;
        clr();
        push(8'hFF, 1'b1, 1'b0);
        wait_idle("rx");
        total++; if (nwords !== 1 || words[0] !== 8'hFF) $display("FAIL rx_mosi: got %h want ff", words[0]); else passed++;
`ifdef SPI_HOST_RX_EN
        total++; if (rx_pulses !== 1) $display("FAIL rx_pulses: got %0d want 1", rx_pulses); else passed++;
        total++; if (rx_last !== 8'h3C) $display("FAIL rx_data: got %h want 3c", rx_last); else passed++;
        total++; if (rxd0 !== 8'h3C) $display("FAIL rx_data_hold: got %h want 3c", rxd0); else passed++;
`else
        total++; if (rx_pulses !== 0) $display("FAIL rx_pulses: got %0d want 0", rx_pulses); else passed++;
        total++; if (rxd0 !== 8'h00) $display("FAIL rx_data: got %h want 00", rxd0); else passed++;
`endif
        $display("test_rx: wrote ff, rx_pulses=%0d rx_data=%h", rx_pulses, rx_last);
    endtask

    task test_gapped();
        int gap_bad;
        gap_bad = 0;
        sel = 1'b0;
        tgt_word = 8'h3C;
        clr();
        push(8'h01, 1'b0, 1'b0);
        wait_ready("gapped1");
        repeat (10) begin
            @(negedge clk);
            if (sclk0 !== 1'b0 || cs0 !== 1'b0) gap_bad++;
        end
        push(8'h02, 1'b0, 1'b0);
        wait_ready("gapped2");
        repeat (10) begin
            @(negedge clk);
            if (sclk0 !== 1'b0 || cs0 !== 1'b0) gap_bad++;
        end
        push(8'h03, 1'b1, 1'b0);
        wait_idle("gapped");
        total++; if (cs_falls !== 1) $display("FAIL gapped_cs_continuous: got %0d falls want 1", cs_falls); else passed++;
        total++; if (rises !== 24) $display("FAIL gapped_rises: got %0d want 24", rises); else passed++;
        total++; if (gap_bad !== 0) $display("FAIL gapped_idle_pins: got %0d bad cycles want 0", gap_bad); else passed++;
        total++; if (nwords !== 3 || words[0] !== 8'h01 || words[1] !== 8'h02 || words[2] !== 8'h03)
            $display("FAIL gapped_mosi: got %0d words %h %h %h want 3 words 01 02 03", nwords, words[0], words[1], words[2]); else passed++;
`ifdef SPI_HOST_RX_EN
        total++; if (rx_pulses !== 3 || rx_last !== 8'h3C) $display("FAIL gapped_rx: got %0d pulses %h want 3 3c", rx_pulses, rx_last); else passed++;
`else
        total++; if (rx_pulses !== 0) $display("FAIL gapped_rx: got %0d pulses want 0", rx_pulses); else passed++;
`endif
        $display("test_gapped: 3-word frame rises=%0d cs_falls=%0d", rises, cs_falls);
    endtask

    task test_reset_mid();
        int n;
        sel = 1'b0;
        tgt_word = 8'h81;
        clr();
        push(8'hFF, 1'b1, 1'b0);
        n = 0;
        while (rises < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++; if (rises < 3) $display("FAIL mid_reach_rise3: got %0d rises want 3", rises); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (cs0 !== 1'b1) $display("FAIL mid_rst_cs: got %b want 1", cs0); else passed++;
        total++; if (sclk0 !== 1'b0) $display("FAIL mid_rst_sclk: got %b want 0", sclk0); else passed++;
        total++; if (mosi0 !== 1'b0) $display("FAIL mid_rst_mosi: got %b want 0", mosi0); else passed++;
        total++; if (busy0 !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy0); else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (rx_pulses !== 0) $display("FAIL mid_no_rx: got %0d pulses want 0", rx_pulses); else passed++;
        clr();
        push(8'h5A, 1'b1, 1'b0);
        wait_idle("mid_fresh");
        total++; if (nwords !== 1 || words[0] !== 8'h5A) $display("FAIL mid_fresh_mosi: got %h want 5a", words[0]); else passed++;
        total++; if (cs_low_len !== 36 || rises !== 8) $display("FAIL mid_fresh_timing: got cs_low=%0d rises=%0d want 36 8", cs_low_len, rises); else passed++;
`ifdef SPI_HOST_RX_EN
        total++; if (rx_pulses !== 1 || rx_last !== 8'h81) $display("FAIL mid_fresh_rx: got %0d %h want 1 81", rx_pulses, rx_last); else passed++;
`endif
        $display("test_reset_mid: abort then fresh 5a, cs_low=%0d", cs_low_len);
    endtask

    task test_back_to_back();
        sel = 1'b1;
        tgt_word = 8'h00;
        clr();
        push(8'h11, 1'b1, 1'b1);
        push(8'h22, 1'b1, 1'b1);
        push(8'h33, 1'b1, 1'b1);
        push(8'h44, 1'b1, 1'b1);
        wait_idle("b2b");
        total++; if (nwords !== 4 || words[0] !== 8'h11 || words[1] !== 8'h22 || words[2] !== 8'h33 || words[3] !== 8'h44)
            $display("FAIL b2b_words: got %0d words %h %h %h %h want 11 22 33 44", nwords, words[0], words[1], words[2], words[3]); else passed++;
        total++; if (rises !== 32) $display("FAIL b2b_rises: got %0d want 32", rises); else passed++;
        total++; if (cs_falls !== 4) $display("FAIL b2b_frames: got %0d want 4", cs_falls); else passed++;
        total++; if (min_gap < 2) $display("FAIL b2b_cs_gap: got %0d want >=2", min_gap); else passed++;
        total++; if (sh_min !== 1 || sh_max !== 1) $display("FAIL b2b_sclk_half: got %0d..%0d want 1..1", sh_min, sh_max); else passed++;
        total++; if (cs_low_len !== 18) $display("FAIL b2b_cs_low: got %0d want 18", cs_low_len); else passed++;
        total++; if (edge_viol !== 0) $display("FAIL b2b_sclk_at_cs_edge: got %0d want 0", edge_viol); else passed++;
        $display("test_back_to_back: 4 frames, min cs gap=%0d", min_gap);
        sel = 1'b0;
    endtask

    task test_no_rx();
        sel = 1'b0;
        miso_rand = 1'b1;
        clr();
        push(8'h96, 1'b1, 1'b0);
        wait_idle("norx");
        miso_rand = 1'b0;
        total++; if (nwords !== 1 || words[0] !== 8'h96) $display("FAIL norx_mosi: got %h want 96", words[0]); else passed++;
        total++; if (cs_low_len !== 36 || rises !== 8) $display("FAIL norx_timing: got cs_low=%0d rises=%0d want 36 8", cs_low_len, rises); else passed++;
`ifdef SPI_HOST_RX_EN
        total++; if (rx_pulses !== 1) $display("FAIL norx_rx_pulses: got %0d want 1", rx_pulses); else passed++;
`else
        total++; if (rx_nz !== 0) $display("FAIL norx_rx_zero: got %0d nonzero cycles want 0", rx_nz); else passed++;
`endif
        $display("test_no_rx: random miso frame 96, rx_pulses=%0d", rx_pulses);
    endtask

    initial begin
        test_reset();
        test_single();
        test_rx();
        test_gapped();
        test_reset_mid();
        test_back_to_back();
        test_no_rx();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
